// File: rtl/rtc_pkg.sv
// Shared definitions for the always-on RTC timekeeping slice.
// Holds control-register bit positions, datapath widths, reset constants
// and the packed control-register layout.
package rtc_pkg;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned DIV_W = 20;
    localparam int unsigned CR_W  = 4;

    localparam int unsigned CR_EN      = 0;
    localparam int unsigned CR_IE      = 1;
    localparam int unsigned CR_WRAP    = 2;
    localparam int unsigned CR_ONESHOT = 3;

    localparam logic [DIV_W-1:0] DIV_RST_DEF = 20'h07FFF;
    localparam logic [CNT_W-1:0] MR_RST_DEF  = 32'hFFFF_FFFF;

    // Control register, MSB first so bit positions match CR_* indices
    typedef struct packed {
        logic oneshot;
        logic wrap;
        logic ie;
        logic en;
    } rtc_cr_t;

endpackage

// File: rtl/rtc_aou_counter_if.sv
// PDU <-> always-on counter bus.
// master: PDU-side APB block (drives write strobes and write data).
// slave : rtc_aou_counter (returns counter, registers and interrupt state).
interface rtc_aou_counter_if;
    import rtc_pkg::*;

    logic              pdu_aou_wen_cr;
    logic              pdu_aou_wen_div;
    logic              pdu_aou_wen_mr;
    logic              pdu_aou_wen_clr_sync;
    logic              pdu_aou_int_clr;
    logic [CNT_W-1:0]  pdu_aou_clr_reg;

    logic [CNT_W-1:0]  aou_pdu_cnt;
    logic [CR_W-1:0]   aou_pdu_cr_reg;
    logic [DIV_W-1:0]  aou_pdu_div_reg;
    logic [CNT_W-1:0]  aou_pdu_mr_reg;
    logic              aou_pdu_intr_mask;
    logic              int_flag;
    logic              rtc_intr;

    modport master (
        output pdu_aou_wen_cr, pdu_aou_wen_div, pdu_aou_wen_mr,
               pdu_aou_wen_clr_sync, pdu_aou_int_clr, pdu_aou_clr_reg,
        input  aou_pdu_cnt, aou_pdu_cr_reg, aou_pdu_div_reg, aou_pdu_mr_reg,
               aou_pdu_intr_mask, int_flag, rtc_intr
    );

    modport slave (
        input  pdu_aou_wen_cr, pdu_aou_wen_div, pdu_aou_wen_mr,
               pdu_aou_wen_clr_sync, pdu_aou_int_clr, pdu_aou_clr_reg,
        output aou_pdu_cnt, aou_pdu_cr_reg, aou_pdu_div_reg, aou_pdu_mr_reg,
               aou_pdu_intr_mask, int_flag, rtc_intr
    );

endinterface

// File: rtl/rtc_aou_wen_sync.sv
// Strobe synchronizer: SYNC_STAGES flops followed by a rising-edge detect.
// Ports: clk, rst (sync, active-high), d (level strobe),
//        pulse_c (one-cycle pulse, combinational from the last two flops).
module rtc_aou_wen_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse_c
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], d};
        last_d  = sync_q[SYNC_STAGES-1];
        pulse_c = sync_q[SYNC_STAGES-1] & ~last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rtc_aou_counter.sv
// Always-on RTC core: prescaler, 32-bit counter, match comparator and
// sticky interrupt flag, updated by synchronized PDU write strobes.
// Ports: rtc_clk, rtc_rst (sync, active-high), bus (slave side of
//        rtc_aou_counter_if carrying strobes, write data and readback).
module rtc_aou_counter
    import rtc_pkg::*;
#(
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [DIV_W-1:0] DIV_RST     = DIV_RST_DEF,
    parameter logic [CNT_W-1:0] MR_RST      = MR_RST_DEF
) (
    input  logic               rtc_clk,
    input  logic               rtc_rst,
    rtc_aou_counter_if.slave   bus
);

    logic cr_pulse_c, div_pulse_c, mr_pulse_c, ld_pulse_c, ic_pulse_c;

    rtc_aou_wen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cr (
        .clk(rtc_clk), .rst(rtc_rst), .d(bus.pdu_aou_wen_cr),       .pulse_c(cr_pulse_c));
    rtc_aou_wen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_div (
        .clk(rtc_clk), .rst(rtc_rst), .d(bus.pdu_aou_wen_div),      .pulse_c(div_pulse_c));
    rtc_aou_wen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mr (
        .clk(rtc_clk), .rst(rtc_rst), .d(bus.pdu_aou_wen_mr),       .pulse_c(mr_pulse_c));
    rtc_aou_wen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ld (
        .clk(rtc_clk), .rst(rtc_rst), .d(bus.pdu_aou_wen_clr_sync), .pulse_c(ld_pulse_c));
    rtc_aou_wen_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ic (
        .clk(rtc_clk), .rst(rtc_rst), .d(bus.pdu_aou_int_clr),      .pulse_c(ic_pulse_c));

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    rtc_cr_t          cr_q,    cr_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0] mr_q,    mr_d;
    logic             flag_q,  flag_d;
    logic             intr_q,  intr_d;

    logic [CNT_W-1:0] wdata_c;
    logic             tick_c, match_c, en_rise_c;

    // Next-state for prescaler, counter, registers and interrupt flag
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        cr_d    = cr_q;
        div_d   = div_q;
        mr_d    = mr_q;
        flag_d  = flag_q;
        intr_d  = flag_q & cr_q.ie;

        wdata_c   = bus.pdu_aou_clr_reg;
        tick_c    = cr_q.en && (presc_q == div_q);
        // A load in the same cycle swallows the tick, so no match either
        match_c   = tick_c && !ld_pulse_c && (cnt_q == mr_q);
        en_rise_c = cr_pulse_c && wdata_c[CR_EN] && !cr_q.en;

        if (div_pulse_c || ld_pulse_c || en_rise_c || tick_c) begin
            presc_d = '0;
        end else if (cr_q.en) begin
            presc_d = presc_q + DIV_W'(1);
        end

        if (ld_pulse_c) begin
            cnt_d = wdata_c;
        end else if (tick_c) begin
            if (match_c && cr_q.wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // CR write beats the one-shot auto-disable
        if (cr_pulse_c) begin
            cr_d = rtc_cr_t'(wdata_c[CR_W-1:0]);
        end else if (match_c && cr_q.oneshot) begin
            cr_d.en = 1'b0;
        end

        if (div_pulse_c) begin
            div_d = wdata_c[DIV_W-1:0];
        end

        if (mr_pulse_c) begin
            mr_d = wdata_c;
        end

        // A new match beats a concurrent clear
        if (match_c) begin
            flag_d = 1'b1;
        end else if (ic_pulse_c) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            presc_q <= '0;
            cnt_q   <= '0;
            cr_q    <= '0;
            div_q   <= DIV_RST;
            mr_q    <= MR_RST;
            flag_q  <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            cr_q    <= cr_d;
            div_q   <= div_d;
            mr_q    <= mr_d;
            flag_q  <= flag_d;
            intr_q  <= intr_d;
        end
    end

    assign bus.aou_pdu_cnt       = cnt_q;
    assign bus.aou_pdu_cr_reg    = cr_q;
    assign bus.aou_pdu_div_reg   = div_q;
    assign bus.aou_pdu_mr_reg    = mr_q;
    assign bus.aou_pdu_intr_mask = ~cr_q.ie;
    assign bus.int_flag          = flag_q;
    assign bus.rtc_intr          = intr_q;

endmodule

// File: tb/tb_rtc_aou_counter.sv
// Testbench for rtc_aou_counter: directed scenarios plus randomized writes
// compared against a cycle-level reference model of the counter rules.
module tb_rtc_aou_counter;
    import rtc_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int K_CR = 0, K_DIV = 1, K_MR = 2, K_LD = 3, K_IC = 4;

    logic rtc_clk = 1'b0;
    logic rtc_rst = 1'b1;

    rtc_aou_counter_if bus();

    rtc_aou_counter #(
        .SYNC_STAGES(SYNC),
        .DIV_RST    (20'h07FFF),
        .MR_RST     (32'hFFFF_FFFF)
    ) dut (
        .rtc_clk(rtc_clk),
        .rtc_rst(rtc_rst),
        .bus    (bus)
    );

    always #5 rtc_clk = ~rtc_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural registers plus pending writes
    int          edge_n = 0;
    int          due [5] = '{-1, -1, -1, -1, -1};
    logic [31:0] dat [5];
    logic [31:0] m_cnt  = '0;
    logic [3:0]  m_cr   = '0;
    logic [19:0] m_div  = 20'h07FFF;
    logic [31:0] m_mr   = 32'hFFFF_FFFF;
    logic        m_flag = 1'b0;
    logic        m_intr = 1'b0;
    int          m_since = 0;   // enabled cycles since the prescaler restarted

    always @(posedge rtc_clk) begin : ref_model
        logic pc, pd, pm, pl, pi, tick, match;
        int   dv;
        edge_n = edge_n + 1;
        if (rtc_rst) begin
            m_cnt = '0; m_cr = '0; m_div = 20'h07FFF; m_mr = 32'hFFFF_FFFF;
            m_flag = 1'b0; m_intr = 1'b0; m_since = 0;
            for (int i = 0; i < 5; i++) due[i] = -1;
        end else begin
            pc = (due[K_CR]  == edge_n);
            pd = (due[K_DIV] == edge_n);
            pm = (due[K_MR]  == edge_n);
            pl = (due[K_LD]  == edge_n);
            pi = (due[K_IC]  == edge_n);
            dv = int'(m_div);
            // one tick every (div+1) enabled cycles
            tick  = m_cr[0] && ((m_since % (dv + 1)) == dv);
            match = tick && !pl && (m_cnt == m_mr);
            m_intr = m_flag & m_cr[1];
            if (pd || pl || (pc && dat[K_CR][0] && !m_cr[0])) m_since = 0;
            else if (m_cr[0]) m_since = m_since + 1;
            if (pl) m_cnt = dat[K_LD];
            else if (tick) m_cnt = (match && m_cr[2]) ? 32'd0 : m_cnt + 32'd1;
            if (match) m_flag = 1'b1;
            else if (pi) m_flag = 1'b0;
            if (pc) m_cr = dat[K_CR][3:0];
            else if (match && m_cr[3]) m_cr[0] = 1'b0;
            if (pd) m_div = dat[K_DIV][19:0];
            if (pm) m_mr = dat[K_MR];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge rtc_clk);
        #1;
    endtask

    task automatic raise(input int k);
        case (k)
            K_CR:    bus.pdu_aou_wen_cr       = 1'b1;
            K_DIV:   bus.pdu_aou_wen_div      = 1'b1;
            K_MR:    bus.pdu_aou_wen_mr       = 1'b1;
            K_LD:    bus.pdu_aou_wen_clr_sync = 1'b1;
            default: bus.pdu_aou_int_clr      = 1'b1;
        endcase
        due[k] = edge_n + int'(SYNC) + 1;
        dat[k] = bus.pdu_aou_clr_reg;
    endtask

    task automatic drop_all();
        bus.pdu_aou_wen_cr       = 1'b0;
        bus.pdu_aou_wen_div      = 1'b0;
        bus.pdu_aou_wen_mr       = 1'b0;
        bus.pdu_aou_wen_clr_sync = 1'b0;
        bus.pdu_aou_int_clr      = 1'b0;
    endtask

    // Write; returns just after the edge on which the update lands
    task automatic wr(input int k, input logic [31:0] d);
        cyc(1);
        bus.pdu_aou_clr_reg = d;
        raise(k);
        cyc(int'(SYNC) + 1);
        drop_all();
    endtask

    task automatic test_reset();
        rtc_rst = 1'b1;
        drop_all();
        bus.pdu_aou_clr_reg = '0;
        cyc(1);
        bus.pdu_aou_clr_reg = 32'hF;
        raise(K_CR);
        cyc(2);
        n_vec++; if (bus.aou_pdu_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got %h exp 0", bus.aou_pdu_cnt); end
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'h0) begin n_err++; $display("FAIL rst_cr got %h exp 0", bus.aou_pdu_cr_reg); end
        n_vec++; if (bus.aou_pdu_div_reg !== 20'h07FFF) begin n_err++; $display("FAIL rst_div got %h exp 07fff", bus.aou_pdu_div_reg); end
        n_vec++; if (bus.aou_pdu_mr_reg !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_mr got %h exp ffffffff", bus.aou_pdu_mr_reg); end
        n_vec++; if (bus.int_flag !== 1'b0) begin n_err++; $display("FAIL rst_flag got %b exp 0", bus.int_flag); end
        n_vec++; if (bus.rtc_intr !== 1'b0) begin n_err++; $display("FAIL rst_intr got %b exp 0", bus.rtc_intr); end
        n_vec++; if (bus.aou_pdu_intr_mask !== 1'b1) begin n_err++; $display("FAIL rst_mask got %b exp 1", bus.aou_pdu_intr_mask); end
        drop_all();
        cyc(2);
        rtc_rst = 1'b0;
        cyc(5);
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'h0) begin n_err++; $display("FAIL rst_abort_cr got %h exp 0", bus.aou_pdu_cr_reg); end
    endtask

    task automatic test_div_en();
        cyc(1);
        bus.pdu_aou_clr_reg = 32'd3;
        raise(K_DIV);
        cyc(10);
        drop_all();
        cyc(2);
        n_vec++; if (bus.aou_pdu_div_reg !== 20'd3) begin n_err++; $display("FAIL div_wr got %h exp 3", bus.aou_pdu_div_reg); end
        bus.pdu_aou_clr_reg = 32'd1;
        raise(K_CR);
        cyc(int'(SYNC) + 1);
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'h1) begin n_err++; $display("FAIL en_cr got %h exp 1", bus.aou_pdu_cr_reg); end
        for (int j = 1; j <= 13; j++) begin
            cyc(1);
            n_vec++;
            if (bus.aou_pdu_cnt !== 32'(j / 4) || bus.aou_pdu_cnt !== m_cnt) begin
                n_err++; $display("FAIL div4_cnt[%0d] got %h exp %h", j, bus.aou_pdu_cnt, 32'(j / 4));
            end
        end
        drop_all();
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'h1) begin n_err++; $display("FAIL held_cr got %h exp 1", bus.aou_pdu_cr_reg); end
    endtask

    task automatic test_wrap_around();
        logic [31:0] exp_cnt;
        wr(K_CR, 32'h0);
        wr(K_DIV, 32'h0);
        wr(K_MR, 32'd5);
        wr(K_LD, 32'hFFFF_FFFE);
        wr(K_CR, 32'h1);
        for (int j = 0; j < 4; j++) begin
            exp_cnt = 32'hFFFF_FFFE + 32'(j);
            n_vec++; if (bus.aou_pdu_cnt !== exp_cnt) begin n_err++; $display("FAIL wrap_cnt[%0d] got %h exp %h", j, bus.aou_pdu_cnt, exp_cnt); end
            n_vec++; if (bus.int_flag !== 1'b0) begin n_err++; $display("FAIL wrap_flag[%0d] got %b exp 0", j, bus.int_flag); end
            cyc(1);
        end
    endtask

    task automatic test_match_wrap();
        wr(K_CR, 32'h0);
        wr(K_DIV, 32'h0);
        wr(K_LD, 32'h0);
        wr(K_MR, 32'd5);
        wr(K_IC, 32'h0);
        wr(K_CR, 32'h7);
        cyc(5);
        n_vec++; if (bus.aou_pdu_cnt !== 32'd5 || bus.int_flag !== 1'b0) begin n_err++; $display("FAIL mw_pre cnt %h flag %b exp 5/0", bus.aou_pdu_cnt, bus.int_flag); end
        cyc(1);
        n_vec++; if (bus.aou_pdu_cnt !== 32'd0 || bus.int_flag !== 1'b1) begin n_err++; $display("FAIL mw_hit cnt %h flag %b exp 0/1", bus.aou_pdu_cnt, bus.int_flag); end
        n_vec++; if (bus.rtc_intr !== 1'b0) begin n_err++; $display("FAIL mw_intr_lag got %b exp 0", bus.rtc_intr); end
        cyc(1);
        n_vec++; if (bus.rtc_intr !== 1'b1) begin n_err++; $display("FAIL mw_intr got %b exp 1", bus.rtc_intr); end
        raise(K_IC);
        cyc(int'(SYNC) + 1);
        n_vec++; if (bus.int_flag !== 1'b0) begin n_err++; $display("FAIL mw_clr_flag got %b exp 0", bus.int_flag); end
        cyc(1);
        n_vec++; if (bus.rtc_intr !== 1'b0) begin n_err++; $display("FAIL mw_clr_intr got %b exp 0", bus.rtc_intr); end
        drop_all();
    endtask

    task automatic test_oneshot();
        wr(K_CR, 32'h0);
        wr(K_LD, 32'h0);
        wr(K_MR, 32'd3);
        wr(K_IC, 32'h0);
        wr(K_CR, 32'hB);
        cyc(8);
        n_vec++; if (bus.aou_pdu_cnt !== 32'd4) begin n_err++; $display("FAIL os_cnt got %h exp 4", bus.aou_pdu_cnt); end
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'hA) begin n_err++; $display("FAIL os_cr got %h exp a", bus.aou_pdu_cr_reg); end
        n_vec++; if (bus.int_flag !== 1'b1 || bus.rtc_intr !== 1'b1) begin n_err++; $display("FAIL os_flag flag %b intr %b exp 1/1", bus.int_flag, bus.rtc_intr); end
        n_vec++; if (bus.aou_pdu_intr_mask !== 1'b0) begin n_err++; $display("FAIL os_mask got %b exp 0", bus.aou_pdu_intr_mask); end
    endtask

    task automatic test_collisions();
        // int_clr landing on the match edge
        wr(K_CR, 32'h0);
        wr(K_LD, 32'h0);
        wr(K_MR, 32'd8);
        wr(K_IC, 32'h0);
        wr(K_CR, 32'h5);
        cyc(6);
        raise(K_IC);
        cyc(int'(SYNC) + 1);
        n_vec++; if (bus.int_flag !== 1'b1 || bus.int_flag !== m_flag) begin n_err++; $display("FAIL col_ic_flag got %b exp 1", bus.int_flag); end
        n_vec++; if (bus.aou_pdu_cnt !== 32'd0) begin n_err++; $display("FAIL col_ic_cnt got %h exp 0", bus.aou_pdu_cnt); end
        drop_all();
        // load landing on a tick that would otherwise match
        wr(K_CR, 32'h0);
        wr(K_LD, 32'd10);
        wr(K_MR, 32'd10);
        wr(K_IC, 32'h0);
        cyc(1);
        bus.pdu_aou_clr_reg = 32'h1234_5671;
        raise(K_CR);
        cyc(1);
        raise(K_LD);
        cyc(2);
        n_vec++; if (bus.aou_pdu_cr_reg !== 4'h1 || bus.aou_pdu_cnt !== 32'd10) begin n_err++; $display("FAIL col_ld_pre cr %h cnt %h exp 1/0000000a", bus.aou_pdu_cr_reg, bus.aou_pdu_cnt); end
        cyc(1);
        n_vec++; if (bus.aou_pdu_cnt !== 32'h1234_5671) begin n_err++; $display("FAIL col_ld_cnt got %h exp 12345671", bus.aou_pdu_cnt); end
        n_vec++; if (bus.int_flag !== 1'b0) begin n_err++; $display("FAIL col_ld_flag got %b exp 0", bus.int_flag); end
        cyc(1);
        drop_all();
        n_vec++; if (bus.aou_pdu_cnt !== 32'h1234_5672) begin n_err++; $display("FAIL col_ld_next got %h exp 12345672", bus.aou_pdu_cnt); end
    endtask

    task automatic test_random();
        int          k, hold, gap;
        logic [31:0] d;
        for (int op = 0; op < 60; op++) begin
            k = int'($urandom_range(0, 4));
            case (k)
                K_CR:    d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
                K_DIV:   d = 32'($urandom_range(0, 2));
                K_MR:    d = 32'($urandom_range(0, 15));
                K_LD:    d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: d = $urandom;
            endcase
            hold = int'($urandom_range(3, 5));
            gap  = int'($urandom_range(1, 3));
            cyc(1);
            bus.pdu_aou_clr_reg = d;
            raise(k);
            for (int c = 0; c < hold + gap; c++) begin
                cyc(1);
                if (c == hold - 1) drop_all();
                n_vec++; if (bus.aou_pdu_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt op %0d got %h exp %h", op, bus.aou_pdu_cnt, m_cnt); end
                n_vec++; if (bus.aou_pdu_cr_reg !== m_cr) begin n_err++; $display("FAIL rnd_cr op %0d got %h exp %h", op, bus.aou_pdu_cr_reg, m_cr); end
                n_vec++; if (bus.aou_pdu_div_reg !== m_div) begin n_err++; $display("FAIL rnd_div op %0d got %h exp %h", op, bus.aou_pdu_div_reg, m_div); end
                n_vec++; if (bus.aou_pdu_mr_reg !== m_mr) begin n_err++; $display("FAIL rnd_mr op %0d got %h exp %h", op, bus.aou_pdu_mr_reg, m_mr); end
                n_vec++; if (bus.int_flag !== m_flag) begin n_err++; $display("FAIL rnd_flag op %0d got %b exp %b", op, bus.int_flag, m_flag); end
                n_vec++; if (bus.rtc_intr !== m_intr) begin n_err++; $display("FAIL rnd_intr op %0d got %b exp %b", op, bus.rtc_intr, m_intr); end
                n_vec++; if (bus.aou_pdu_intr_mask !== ~m_cr[CR_IE]) begin n_err++; $display("FAIL rnd_mask op %0d got %b exp %b", op, bus.aou_pdu_intr_mask, ~m_cr[CR_IE]); end
            end
        end
    endtask

    initial begin
        drop_all();
        bus.pdu_aou_clr_reg = '0;
        test_reset();
        test_div_en();
        test_wrap_around();
        test_match_wrap();
        test_oneshot();
        test_collisions();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
